// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller: FSM encoding and default widths.
package ram_ctrl_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ADDRWIDTH = 10;
  localparam int DEF_LENWIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address/beat counter: loads start address and beats-minus-one, advances one beat per strobe.
module burst_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int LENWIDTH  = DEF_LENWIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_load,
  input  logic [ADDRWIDTH-1:0] i_addr,
  input  logic [LENWIDTH-1:0]  i_len,
  input  logic                 i_adv,
  output logic [ADDRWIDTH-1:0] o_addr,
  output logic                 o_last
);

  logic [ADDRWIDTH-1:0] r_addr;
  logic [LENWIDTH-1:0]  r_cnt;

  // Address rolls over naturally at 2^ADDRWIDTH; a wrap mid-burst is legal.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_cnt  <= i_len;
    end else if (i_adv) begin
      r_addr <= r_addr + ADDRWIDTH'(1);
      r_cnt  <= r_cnt - LENWIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a combinational-read RAM: valid/ready request, write and read-beat channels.
// state  | meaning
// IDLE   | waiting for a request, no RAM access
// WRITE  | one RAM write per accepted write beat
// READ   | reading words into the one-entry output stage
// DONE   | one-cycle completion pulse
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int LENWIDTH  = DEF_LENWIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [ADDRWIDTH-1:0] req_addr_i,
  input  logic [LENWIDTH-1:0]  req_len_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [DATAWIDTH-1:0] wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DATAWIDTH-1:0] rd_data_o,
  output logic                 rd_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDRWIDTH-1:0] ram_addr_o,
  output logic [DATAWIDTH-1:0] ram_wdata_o,
  input  logic [DATAWIDTH-1:0] ram_rdata_i,
  output logic                 ram_wen_o
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_rd_capture;
  logic [ADDRWIDTH-1:0]  w_addr_q;
  logic                  w_last;
  logic                  r_rd_issued;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [DATAWIDTH-1:0]  r_rd_data;

  burst_addr_gen #(
    .ADDRWIDTH (ADDRWIDTH),
    .LENWIDTH  (LENWIDTH)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_load),
    .i_addr (req_addr_i),
    .i_len  (req_len_i),
    .i_adv  (w_adv),
    .o_addr (w_addr_q),
    .o_last (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = req_write_i ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_valid_i) begin
          w_adv = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
      ST_READ: begin
        // Output stage refills in the same cycle it drains, giving one beat per cycle.
        w_rd_capture = !r_rd_issued && (!r_rd_valid || rd_ready_i);
        w_adv        = w_rd_capture;
        if (r_rd_valid && rd_ready_i && r_rd_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat counter wraps after the last capture, so remember that the burst is fully issued.
  always_ff @(posedge clk_i) begin
    if (rst_i)                      r_rd_issued <= 1'b0;
    else if (w_load)                r_rd_issued <= 1'b0;
    else if (w_rd_capture && w_last) r_rd_issued <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_rd_capture) begin
      r_rd_valid <= 1'b1;
      r_rd_last  <= w_last;
      r_rd_data  <= ram_rdata_i;
    end else if (r_rd_valid && rd_ready_i) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign wr_ready_o  = (r_state == ST_WRITE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign rd_valid_o  = r_rd_valid;
  assign rd_last_o   = r_rd_last;
  assign rd_data_o   = r_rd_data;
  assign ram_addr_o  = ((r_state == ST_WRITE) || (r_state == ST_READ)) ? w_addr_q : '0;
  assign ram_wdata_o = wr_data_i;
  // Gated by rst_i directly so an abort cannot write the beat presented in the reset cycle.
  assign ram_wen_o   = !rst_i && (r_state == ST_WRITE) && wr_valid_i;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl with a behavioural RAM responder and an array reference model.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [9:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       done;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       ram_wen;

  logic [7:0] ram_mem [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] g_wdata [16];
  int total = 0;
  int bad = 0;
  int wen_cnt = 0;

  ram_burst_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .busy_o      (busy),
    .done_o      (done),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .ram_wen_o   (ram_wen)
  );

  always #5 clk = ~clk;

  // RAM responder: combinational read, write on the rising edge.
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (ram_wen) begin
      ram_mem[ram_addr] = ram_wdata;
      wen_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pat_bit(input logic [31:0] p, input int k);
    return (k > 31) ? 1'b1 : p[k];
  endfunction

  task automatic start_req(input logic wr, input logic [9:0] a, input logic [3:0] len, input bit hold);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_timeout", 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    chk("req_accept_busy", 32'(busy), 32'(1));
  endtask

  task automatic write_beats(input logic [9:0] a, input int len, input logic [31:0] pat, input bit hold);
    int idx = 0;
    int cyc = 0;
    logic [9:0] ea;
    while (idx <= len && cyc < 200) begin
      wr_valid = pat_bit(pat, cyc);
      wr_data  = g_wdata[idx];
      #1;
      ea = a + idx[9:0];
      chk("wr_ready", 32'(wr_ready), 32'(1));
      chk("wr_addr", 32'(ram_addr), 32'(ea));
      chk("wr_wen", 32'(ram_wen), 32'(wr_valid));
      if (wr_valid) chk("wr_wdata", 32'(ram_wdata), 32'(g_wdata[idx]));
      if (hold) chk("req_ready_busy", 32'(req_ready), 32'(0));
      @(posedge clk); #1;
      if (wr_valid) begin
        ref_mem[ea] = g_wdata[idx];
        idx++;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    if (idx <= len) chk("wr_timeout", 32'(idx), 32'(len + 1));
  endtask

  task automatic read_beats(input logic [9:0] a, input int len, input logic [31:0] pat);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit stl = 1'b0;
    logic [7:0] pd;
    logic [9:0] pa;
    logic pl;
    logic [9:0] ea;
    while (idx <= len && cyc < 200) begin
      rd_ready = pat_bit(pat, cyc);
      if (cyc == 0) chk("rd_lat_t1", 32'(rd_valid), 32'(0));
      if (cyc == 1) chk("rd_lat_t2", 32'(rd_valid), 32'(1));
      chk("rd_no_wen", 32'(ram_wen), 32'(0));
      if (stl) begin
        chk("rd_stall_data", 32'(rd_data), 32'(pd));
        chk("rd_stall_last", 32'(rd_last), 32'(pl));
        chk("rd_stall_addr", 32'(ram_addr), 32'(pa));
      end
      if (rd_valid) begin
        ea = a + idx[9:0];
        chk("rd_data", 32'(rd_data), 32'(ref_mem[ea]));
        chk("rd_last", 32'(rd_last), 32'(idx == len));
      end
      stl = rd_valid && !rd_ready;
      pd  = rd_data;
      pa  = ram_addr;
      pl  = rd_last;
      acc = rd_valid && rd_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    rd_ready = 1'b0;
    if (idx <= len) chk("rd_timeout", 32'(idx), 32'(len + 1));
    chk("rd_valid_after", 32'(rd_valid), 32'(0));
  endtask

  task automatic finish_burst();
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_not_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("idle_ready", 32'(req_ready), 32'(1));
    chk("idle_not_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    int w0;
    logic [9:0] ra;
    int rl;
    bit rw;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end

    // Reset state, with wr_valid asserted to show no write leaks through.
    wr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", 32'(ram_wen), 32'(0));
    wr_valid = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_rd_last", 32'(rd_last), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single beat write/read.
    g_wdata[0] = 8'hA5;
    start_req(1'b1, 10'h005, 4'd0, 1'b0);
    write_beats(10'h005, 0, 32'hFFFF_FFFF, 1'b0);
    finish_burst();
    chk("t1_mem", 32'(ram_mem[5]), 32'h0000_00A5);
    start_req(1'b0, 10'h005, 4'd0, 1'b0);
    read_beats(10'h005, 0, 32'hFFFF_FFFF);
    finish_burst();

    // Address wrap.
    g_wdata[0] = 8'h11; g_wdata[1] = 8'h22; g_wdata[2] = 8'h33; g_wdata[3] = 8'h44;
    start_req(1'b1, 10'h3FE, 4'd3, 1'b0);
    write_beats(10'h3FE, 3, 32'hFFFF_FFFF, 1'b0);
    finish_burst();
    chk("wrap_3fe", 32'(ram_mem[10'h3FE]), 32'h11);
    chk("wrap_3ff", 32'(ram_mem[10'h3FF]), 32'h22);
    chk("wrap_000", 32'(ram_mem[10'h000]), 32'h33);
    chk("wrap_001", 32'(ram_mem[10'h001]), 32'h44);
    start_req(1'b0, 10'h3FE, 4'd3, 1'b0);
    read_beats(10'h3FE, 3, 32'hFFFF_FFFF);
    finish_burst();

    // Read backpressure: ready low for 3 cycles after the first beat.
    for (int i = 0; i < 4; i++) g_wdata[i] = 8'($urandom);
    start_req(1'b1, 10'h040, 4'd3, 1'b0);
    write_beats(10'h040, 3, 32'hFFFF_FFFF, 1'b0);
    finish_burst();
    start_req(1'b0, 10'h040, 4'd3, 1'b0);
    read_beats(10'h040, 3, 32'hFFFF_FFE3);
    finish_burst();

    // Write stall pattern 1,0,0,1,1,0,1.
    for (int i = 0; i < 4; i++) g_wdata[i] = 8'($urandom);
    w0 = wen_cnt;
    start_req(1'b1, 10'h080, 4'd3, 1'b0);
    write_beats(10'h080, 3, 32'hFFFF_FFD9, 1'b0);
    finish_burst();
    chk("stall_wen_count", 32'(wen_cnt - w0), 32'(4));

    // Reset on beat 2 of an 8-beat write.
    for (int i = 0; i < 8; i++) g_wdata[i] = 8'($urandom);
    start_req(1'b1, 10'h100, 4'd7, 1'b0);
    write_beats(10'h100, 1, 32'hFFFF_FFFF, 1'b0);
    wr_valid = 1'b1;
    wr_data  = g_wdata[2];
    rst      = 1'b1;
    #1;
    chk("rst_mid_wen", 32'(ram_wen), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'(1));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_done", 32'(done), 32'(0));
      @(posedge clk); #1;
    end
    chk("rst_mid_word2", 32'(ram_mem[10'h102]), 32'(ref_mem[10'h102]));

    // 16-beat write with request held high; the held read request is taken after done.
    for (int i = 0; i < 16; i++) g_wdata[i] = 8'($urandom);
    start_req(1'b1, 10'h200, 4'd15, 1'b1);
    req_write = 1'b0;
    write_beats(10'h200, 15, 32'hFFFF_FFFF, 1'b1);
    finish_burst();
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("held_req_accept", 32'(busy), 32'(1));
    read_beats(10'h200, 15, 32'hFFFF_FFFF);
    finish_burst();

    // Randomized bursts with random stalls on both channels.
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 10'($urandom_range(0, 1023));
      rl = int'($urandom_range(0, 15));
      if (n < 4) ra = 10'h3F8 + 10'(n);
      if (rw) begin
        for (int i = 0; i < 16; i++) g_wdata[i] = 8'($urandom);
        start_req(1'b1, ra, 4'(rl), 1'b0);
        write_beats(ra, rl, $urandom, 1'b0);
      end else begin
        start_req(1'b0, ra, 4'(rl), 1'b0);
        read_beats(ra, rl, $urandom);
      end
      finish_burst();
    end

    for (int i = 0; i < 1024; i++) chk("mem_final", 32'(ram_mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
